// File: rtl/vga_rect_filler_pkg.sv
// rtl/vga_rect_filler_pkg.sv - shared types and helpers for the VGA rectangle fill engine
package vga_rect_filler_pkg;

    // Colour mode latched at start; encoding 3 is folded into SOLID by decode_mode.
    typedef enum logic [1:0] {
        SOLID     = 2'd0,
        HUE_FRAME = 2'd1,
        HUE_COL   = 2'd2
    } fill_mode_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        FILL     = 3'd2,
        STEP_HUE = 3'd3,
        DONE     = 3'd4
    } fill_state_t;

    // Hue ramp phase 0..5: G up, R down, B up, G down, R up, B down.
    typedef logic [2:0] hue_phase_t;

    localparam hue_phase_t PHASE_FIRST = 3'd0;
    localparam hue_phase_t PHASE_LAST  = 3'd5;

    function automatic fill_mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return HUE_FRAME;
            2'd2:    return HUE_COL;
            default: return SOLID;
        endcase
    endfunction

endpackage

// File: rtl/vga_rect_filler_hue_ramp.sv
// rtl/vga_rect_filler_hue_ramp.sv - combinational one-step hue ramp (colour+phase -> next colour+phase)
//
// Ports:
//   color_i   {R,G,B} current hue, CW bits per channel
//   phase_i   current ramp phase 0..5
//   color_o   hue after one step
//   phase_o   phase after one step
//   wrapped_o high when the saturating step leaves phase 5 (ramp back at red)
module vga_rect_filler_hue_ramp
    import vga_rect_filler_pkg::*;
#(
    parameter int              CW   = 8,
    parameter logic [CW-1:0]   STEP = CW'(8'h11)
) (
    input  logic [3*CW-1:0] color_i,
    input  hue_phase_t      phase_i,
    output logic [3*CW-1:0] color_o,
    output hue_phase_t      phase_o,
    output logic            wrapped_o
);

    localparam logic [CW-1:0] M = {CW{1'b1}};

    logic [CW-1:0] r, g, b;
    logic [CW-1:0] r_n, g_n, b_n;
    logic [CW-1:0] cur, nxt;
    logic          rising, sat;

    assign r = color_i[3*CW-1:2*CW];
    assign g = color_i[2*CW-1:CW];
    assign b = color_i[CW-1:0];

    always_comb begin
        rising = 1'b0;
        cur    = b;
        case (phase_i)
            3'd0: begin cur = g; rising = 1'b1; end
            3'd1: cur = r;
            3'd2: begin cur = b; rising = 1'b1; end
            3'd3: cur = g;
            3'd4: begin cur = r; rising = 1'b1; end
            default: cur = b;
        endcase

        // The step that reaches the rail (exactly or by clipping) is the one that moves the phase on.
        if (rising) begin
            sat = (cur >= M - STEP);
            nxt = sat ? M : cur + STEP;
        end else begin
            sat = (cur <= STEP);
            nxt = sat ? '0 : cur - STEP;
        end

        r_n = r;
        g_n = g;
        b_n = b;
        case (phase_i)
            3'd0, 3'd3: g_n = nxt;
            3'd1, 3'd4: r_n = nxt;
            default:    b_n = nxt;
        endcase

        color_o   = {r_n, g_n, b_n};
        wrapped_o = sat && (phase_i >= PHASE_LAST);
        if (!sat)
            phase_o = phase_i;
        else if (phase_i >= PHASE_LAST)
            phase_o = PHASE_FIRST;
        else
            phase_o = phase_i + 3'd1;
    end

endmodule

// File: rtl/vga_rect_filler.sv
// rtl/vga_rect_filler.sv - VGA rectangle fill engine, one pixel per cycle, solid/hue-frame/hue-column
//
// Optional feature macro: VGA_RECT_FILLER_CLEAR_EN (clear whole screen to black before each fill).
//
// Ports:
//   CLOCK_50, Resetn           clock, synchronous active-low reset
//   start, abort               request (sampled in IDLE) / stop (honoured while busy)
//   mode                       0 SOLID, 1 HUE_FRAME, 2 HUE_COL, 3 SOLID
//   x0,x1,y0,y1                rectangle corners, any order
//   base_color                 {R,G,B} for SOLID
//   VGA_X,VGA_Y,VGA_COLOR,plot registered pixel-write port
//   busy, done                 operation in progress / one-cycle completion pulse
module vga_rect_filler
    import vga_rect_filler_pkg::*;
#(
    parameter int            nX   = 8,
    parameter int            nY   = 7,
    parameter int            COLS = 160,
    parameter int            ROWS = 120,
    parameter int            CW   = 8,
    parameter logic [CW-1:0] STEP = CW'(8'h11)
) (
    input  logic            CLOCK_50,
    input  logic            Resetn,
    input  logic            start,
    input  logic            abort,
    input  logic [1:0]      mode,
    input  logic [nX-1:0]   x0,
    input  logic [nX-1:0]   x1,
    input  logic [nY-1:0]   y0,
    input  logic [nY-1:0]   y1,
    input  logic [3*CW-1:0] base_color,
    output logic [nX-1:0]   VGA_X,
    output logic [nY-1:0]   VGA_Y,
    output logic [3*CW-1:0] VGA_COLOR,
    output logic            plot,
    output logic            busy,
    output logic            done
);

    localparam logic [3*CW-1:0] RED = {{CW{1'b1}}, {(2*CW){1'b0}}};

    if (COLS > (1 << nX) || ROWS > (1 << nY)) begin : g_bad_geometry
        $error("COLS/ROWS do not fit the VGA coordinate widths");
    end

    fill_state_t     state_q, state_d;
    fill_mode_t      mode_q, mode_d;
    logic [3*CW-1:0] base_q, base_d;
    logic [nX-1:0]   xl_q, xl_d, xh_q, xh_d, x_q, x_d;
    logic [nY-1:0]   yl_q, yl_d, yh_q, yh_d, y_q, y_d;
    logic [3*CW-1:0] hue_q, hue_d;
    hue_phase_t      phase_q, phase_d;
    logic [3*CW-1:0] color_q, color_d;
    logic            plot_q, plot_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [3*CW-1:0] ramp_color;
    hue_phase_t      ramp_phase;
    logic            ramp_wrapped;

    vga_rect_filler_hue_ramp #(
        .CW   (CW),
        .STEP (STEP)
    ) u_hue_ramp (
        .color_i   (hue_q),
        .phase_i   (phase_q),
        .color_o   (ramp_color),
        .phase_o   (ramp_phase),
        .wrapped_o (ramp_wrapped)
    );

    // The registered outputs always describe the pixel being written this cycle, so each
    // transition below computes the pixel for the *next* cycle; abort therefore suppresses
    // the pixel that would have been registered at that edge.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        base_d  = base_q;
        xl_d    = xl_q;
        xh_d    = xh_q;
        yl_d    = yl_q;
        yh_d    = yh_q;
        x_d     = x_q;
        y_d     = y_q;
        hue_d   = hue_q;
        phase_d = phase_q;
        color_d = color_q;
        plot_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d  = decode_mode(mode);
                    base_d  = base_color;
                    xl_d    = (x0 <= x1) ? x0 : x1;
                    xh_d    = (x0 <= x1) ? x1 : x0;
                    yl_d    = (y0 <= y1) ? y0 : y1;
                    yh_d    = (y0 <= y1) ? y1 : y0;
                    hue_d   = RED;
                    phase_d = PHASE_FIRST;
                    plot_d  = 1'b1;
`ifdef VGA_RECT_FILLER_CLEAR_EN
                    state_d = CLEAR;
                    x_d     = '0;
                    y_d     = '0;
`else
                    state_d = FILL;
                    x_d     = xl_d;
                    y_d     = yl_d;
`endif
                end
            end
`ifdef VGA_RECT_FILLER_CLEAR_EN
            CLEAR: begin
                if (abort) begin
                    state_d = DONE;
                end else begin
                    plot_d = 1'b1;
                    if (x_q != nX'(COLS - 1)) begin
                        x_d = x_q + nX'(1);
                    end else if (y_q != nY'(ROWS - 1)) begin
                        x_d = '0;
                        y_d = y_q + nY'(1);
                    end else begin
                        state_d = FILL;
                        x_d     = xl_q;
                        y_d     = yl_q;
                    end
                end
            end
`endif
            FILL: begin
                if (abort) begin
                    state_d = DONE;
                end else if (x_q != xh_q) begin
                    x_d    = x_q + nX'(1);
                    plot_d = 1'b1;
                    if (mode_q == HUE_COL) begin
                        hue_d   = ramp_color;
                        phase_d = ramp_phase;
                    end
                end else if (y_q != yh_q) begin
                    x_d    = xl_q;
                    y_d    = y_q + nY'(1);
                    plot_d = 1'b1;
                    if (mode_q == HUE_COL) begin
                        hue_d   = RED;
                        phase_d = PHASE_FIRST;
                    end
                end else begin
                    state_d = (mode_q == HUE_FRAME) ? STEP_HUE : DONE;
                end
            end
            STEP_HUE: begin
                if (abort) begin
                    state_d = DONE;
                end else begin
                    hue_d   = ramp_color;
                    phase_d = ramp_phase;
                    // Returning to red ends the sweep; the red frame is not painted twice.
                    if (ramp_wrapped) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                        x_d     = xl_q;
                        y_d     = yl_q;
                        plot_d  = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (plot_d)
            color_d = (state_d != FILL) ? '0 : (mode_d == SOLID) ? base_d : hue_d;

        busy_d = (state_d == CLEAR) || (state_d == FILL) || (state_d == STEP_HUE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q <= IDLE;
            mode_q  <= SOLID;
            base_q  <= '0;
            xl_q    <= '0;
            xh_q    <= '0;
            yl_q    <= '0;
            yh_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hue_q   <= RED;
            phase_q <= PHASE_FIRST;
            color_q <= '0;
            plot_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            base_q  <= base_d;
            xl_q    <= xl_d;
            xh_q    <= xh_d;
            yl_q    <= yl_d;
            yh_q    <= yh_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hue_q   <= hue_d;
            phase_q <= phase_d;
            color_q <= color_d;
            plot_q  <= plot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign VGA_X     = x_q;
    assign VGA_Y     = y_q;
    assign VGA_COLOR = color_q;
    assign plot      = plot_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
